sram_arbiter: RTL and testbench

//  Shares the single async SRAM between two requesters: the CPU datapath
//  (fetch / LDR / STR) and a debug/init port (memory loader, LED/switch I/O).

---
 rtl/sram_arb_pkg.sv | 15 +
 rtl/rr_arbiter2.sv | 16 +
 rtl/sram_arbiter.sv | 146 ++++++++++++++
 tb/tb_sram_arbiter.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_arb_pkg.sv
// Shared types for the SRAM arbiter: FSM states and access-owner encoding.
package sram_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        ACK    = 2'd2
    } arb_state_t;

    typedef enum logic {
        OWN_CPU = 1'b0,
        OWN_DBG = 1'b1
    } owner_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin picker: a lone request wins outright, a tie goes to the
// requester that was not granted last. Purely combinational.
module rr_arbiter2 (
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic [1:0] grant
);

    always_comb begin
        grant = req;
        if (req == 2'b11) begin
            grant = last_grant ? 2'b01 : 2'b10;
        end
    end

endmodule

// File: rtl/sram_arbiter.sv
// Arbitrates the single async SRAM between the CPU and debug ports and generates
// the active-low strobes from registered state only.
module sram_arbiter
    import sram_arb_pkg::*;
#(
    parameter int ADDR_W    = 20,
    parameter int DATA_W    = 16,
    parameter int RD_CYCLES = 2,
    parameter int WR_CYCLES = 2
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_ack,
    input  logic              dbg_req,
    input  logic              dbg_we,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [DATA_W-1:0] dbg_wdata,
    output logic [DATA_W-1:0] dbg_rdata,
    output logic              dbg_ack,
    output logic              Mem_CE,
    output logic              Mem_OE,
    output logic              Mem_WE,
    output logic              Mem_UB,
    output logic              Mem_LB,
    output logic [ADDR_W-1:0] ADDR,
    output logic [DATA_W-1:0] Data_to_SRAM,
    output logic              Data_oe,
    input  logic [DATA_W-1:0] Data_from_SRAM
);

    localparam int MAX_CYC = (RD_CYCLES > WR_CYCLES) ? RD_CYCLES : WR_CYCLES;
    localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    arb_state_t        state;
    arb_state_t        next_state;
    owner_t            owner;
    owner_t            last_grant;
    logic              we_q;
    logic [CNT_W-1:0]  cnt;
    logic [1:0]        grant;
    logic              sel_dbg;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;

    rr_arbiter2 u_rr (
        .req        ({dbg_req, cpu_req}),
        .last_grant (last_grant == OWN_DBG),
        .grant      (grant)
    );

    assign sel_dbg   = grant[1];
    assign sel_we    = sel_dbg ? dbg_we    : cpu_we;
    assign sel_addr  = sel_dbg ? dbg_addr  : cpu_addr;
    assign sel_wdata = sel_dbg ? dbg_wdata : cpu_wdata;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (cpu_req || dbg_req) next_state = ACCESS;
            ACCESS:  if (cnt == '0)          next_state = ACK;
            ACK:     next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Grant-time latches, strobe countdown and read capture on the final ACCESS edge
    always_ff @(posedge Clk) begin
        if (Reset) begin
            ADDR         <= '0;
            Data_to_SRAM <= '0;
            we_q         <= 1'b0;
            owner        <= OWN_CPU;
            last_grant   <= OWN_DBG;
            cnt          <= '0;
            cpu_rdata    <= '0;
            dbg_rdata    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant != 2'b00) begin
                        ADDR         <= sel_addr;
                        Data_to_SRAM <= sel_wdata;
                        we_q         <= sel_we;
                        owner        <= sel_dbg ? OWN_DBG : OWN_CPU;
                        last_grant   <= sel_dbg ? OWN_DBG : OWN_CPU;
                        cnt          <= sel_we ? CNT_W'(WR_CYCLES - 1) : CNT_W'(RD_CYCLES - 1);
                    end
                end
                ACCESS: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else if (!we_q) begin
                        if (owner == OWN_DBG) dbg_rdata <= Data_from_SRAM;
                        else                  cpu_rdata <= Data_from_SRAM;
                    end
                end
                default: ;
            endcase
        end
    end

    // Data_oe lingers through ACK on writes so the SRAM sees data hold after WE rises
    always_comb begin
        Mem_CE  = 1'b1;
        Mem_OE  = 1'b1;
        Mem_WE  = 1'b1;
        Data_oe = 1'b0;
        cpu_ack = 1'b0;
        dbg_ack = 1'b0;
        case (state)
            ACCESS: begin
                Mem_CE = 1'b0;
                if (we_q) begin
                    Mem_WE  = 1'b0;
                    Data_oe = 1'b1;
                end else begin
                    Mem_OE = 1'b0;
                end
            end
            ACK: begin
                Data_oe = we_q;
                cpu_ack = (owner == OWN_CPU);
                dbg_ack = (owner == OWN_DBG);
            end
            default: ;
        endcase
    end

    assign Mem_UB = 1'b0;
    assign Mem_LB = 1'b0;

endmodule

// File: tb/tb_sram_arbiter.sv
// Scoreboard bench for sram_arbiter with a behavioural async SRAM model.
module tb_sram_arbiter;
    import sram_arb_pkg::*;

    localparam int ADDR_W = 20;
    localparam int DATA_W = 16;

    logic              Clk = 1'b0;
    logic              Reset = 1'b1;
    logic              cpu_req = 1'b0, cpu_we = 1'b0;
    logic [ADDR_W-1:0] cpu_addr = '0;
    logic [DATA_W-1:0] cpu_wdata = '0;
    logic [DATA_W-1:0] cpu_rdata;
    logic              cpu_ack;
    logic              dbg_req = 1'b0, dbg_we = 1'b0;
    logic [ADDR_W-1:0] dbg_addr = '0;
    logic [DATA_W-1:0] dbg_wdata = '0;
    logic [DATA_W-1:0] dbg_rdata;
    logic              dbg_ack;
    logic              Mem_CE, Mem_OE, Mem_WE, Mem_UB, Mem_LB;
    logic [ADDR_W-1:0] ADDR;
    logic [DATA_W-1:0] Data_to_SRAM;
    logic              Data_oe;
    logic [DATA_W-1:0] Data_from_SRAM;

    sram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_CYCLES(2), .WR_CYCLES(2)) dut (
        .Clk(Clk), .Reset(Reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
        .dbg_rdata(dbg_rdata), .dbg_ack(dbg_ack),
        .Mem_CE(Mem_CE), .Mem_OE(Mem_OE), .Mem_WE(Mem_WE), .Mem_UB(Mem_UB), .Mem_LB(Mem_LB),
        .ADDR(ADDR), .Data_to_SRAM(Data_to_SRAM), .Data_oe(Data_oe),
        .Data_from_SRAM(Data_from_SRAM)
    );

    always #5 Clk = ~Clk;

    function automatic logic [15:0] init_val(input int a);
        logic [15:0] v;
        v = a[15:0];
        return v ^ 16'hA5A5;
    endfunction

    // Async SRAM: reads while CE/OE low, writes on clock edges while CE/WE low
    logic [15:0] mem [0:1023];
    logic        loaded = 1'b0;
    assign Data_from_SRAM = (!Mem_CE && !Mem_OE) ? mem[ADDR[9:0]] : 16'hDEAD;
    always @(posedge Clk) begin
        if (!loaded) begin
            for (int i = 0; i < 1024; i++) mem[i] <= init_val(i);
            mem[16] <= 16'h1234;
            loaded  <= 1'b1;
        end else if (!Mem_CE && !Mem_WE && Data_oe) begin
            mem[ADDR[9:0]] <= Data_to_SRAM;
        end
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    endtask

    typedef struct {
        logic        port;
        logic        is_rd;
        logic [15:0] data;
    } exp_t;
    exp_t sb[$];

    task automatic expect_txn(input logic port, input logic is_rd, input logic [15:0] d);
        exp_t e;
        e.port  = port;
        e.is_rd = is_rd;
        e.data  = d;
        sb.push_back(e);
    endtask

    always @(negedge Clk) begin : monitor
        exp_t e;
        if (!Reset) begin
            check_eq("oe_we_excl", {31'd0, (!Mem_OE && !Mem_WE)}, 32'd0);
            check_eq("ub_lb", {30'd0, Mem_UB, Mem_LB}, 32'd0);
            check_eq("ce_decode", {31'd0, Mem_CE}, {31'd0, (Mem_OE & Mem_WE)});
            if (cpu_ack && dbg_ack) check_eq("dual_ack", 32'd1, 32'd0);
            if (cpu_ack || dbg_ack) begin
                if (sb.size() == 0) begin
                    check_eq("unexpected_ack", {30'd0, dbg_ack, cpu_ack}, 32'd0);
                end else begin
                    e = sb.pop_front();
                    check_eq("ack_port", {31'd0, dbg_ack}, {31'd0, e.port});
                    if (e.is_rd) check_eq("rdata", {16'd0, (dbg_ack ? dbg_rdata : cpu_rdata)}, {16'd0, e.data});
                end
            end
        end
    end

    task automatic set_req(input logic port, input logic v);
        if (port) dbg_req = v;
        else      cpu_req = v;
    endtask

    task automatic drive(input logic port, input logic we, input logic [ADDR_W-1:0] a, input logic [15:0] d);
        if (port) begin dbg_we = we; dbg_addr = a; dbg_wdata = d; dbg_req = 1'b1; end
        else      begin cpu_we = we; cpu_addr = a; cpu_wdata = d; cpu_req = 1'b1; end
    endtask

    // Called just after a rising edge; cycle 0 is the cycle the request is first visible
    task automatic run_single(input logic port, input logic we, input logic [ADDR_W-1:0] a,
                              input logic [15:0] d, input int hold,
                              output logic [15:0] ack_log, output logic [15:0] oe_log,
                              output logic [15:0] we_log, output logic [15:0] doe_log);
        int drop_at;
        drop_at = -1;
        ack_log = '0; oe_log = '0; we_log = '0; doe_log = '0;
        drive(port, we, a, d);
        for (int k = 0; k < 12; k++) begin
            if (k > 0) begin
                @(posedge Clk); #1;
                if (k == drop_at) set_req(port, 1'b0);
            end
            @(negedge Clk);
            ack_log[k] = cpu_ack | dbg_ack;
            oe_log[k]  = !Mem_OE;
            we_log[k]  = !Mem_WE;
            doe_log[k] = Data_oe;
            if ((port ? dbg_ack : cpu_ack) && drop_at < 0) drop_at = k + 1 + hold;
        end
        @(posedge Clk); #1;
        set_req(port, 1'b0);
    endtask

    task automatic do_reset(input int cycles);
        Reset = 1'b1;
        repeat (cycles) begin @(posedge Clk); #1; end
        Reset = 1'b0;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : stim
        logic [15:0] ack_l, oe_l, we_l, doe_l;
        int got, cpu_k, dbg_k, ack_cyc;
        logic ack_port;

        @(posedge Clk); #1;
        do_reset(3);
        @(negedge Clk);
        check_eq("rst_strobes", {29'd0, Mem_CE, Mem_OE, Mem_WE}, 32'd7);
        check_eq("rst_acks", {30'd0, cpu_ack, dbg_ack}, 32'd0);
        check_eq("rst_data_oe", {31'd0, Data_oe}, 32'd0);
        check_eq("rst_addr", {12'd0, ADDR}, 32'd0);
        check_eq("rst_wdata", {16'd0, Data_to_SRAM}, 32'd0);
        check_eq("rst_rdata", {cpu_rdata, dbg_rdata}, 32'd0);
        check_eq("rst_state", {30'd0, dut.state}, {30'd0, IDLE});
        @(posedge Clk); #1;

        // CPU read of preloaded word
        expect_txn(1'b0, 1'b1, 16'h1234);
        run_single(1'b0, 1'b0, 20'h00010, 16'h0, 0, ack_l, oe_l, we_l, doe_l);
        check_eq("t1_oe_cycles", {16'd0, oe_l}, 32'h0006);
        check_eq("t1_we_cycles", {16'd0, we_l}, 32'h0000);
        check_eq("t1_ack_cycle", {16'd0, ack_l}, 32'h0008);

        // Debug write then CPU readback
        expect_txn(1'b1, 1'b0, 16'h0);
        run_single(1'b1, 1'b1, 20'h00020, 16'hBEEF, 0, ack_l, oe_l, we_l, doe_l);
        check_eq("t2_we_cycles", {16'd0, we_l}, 32'h0006);
        check_eq("t2_oe_cycles", {16'd0, oe_l}, 32'h0000);
        check_eq("t2_data_oe", {16'd0, doe_l}, 32'h000E);
        check_eq("t2_ack_cycle", {16'd0, ack_l}, 32'h0008);
        expect_txn(1'b0, 1'b1, 16'hBEEF);
        run_single(1'b0, 1'b0, 20'h00020, 16'h0, 0, ack_l, oe_l, we_l, doe_l);
        check_eq("t2_rb_ack", {16'd0, ack_l}, 32'h0008);

        // Req held one cycle past ack is a second transaction
        expect_txn(1'b0, 1'b1, init_val(32'h44));
        expect_txn(1'b0, 1'b1, init_val(32'h44));
        run_single(1'b0, 1'b0, 20'h00044, 16'h0, 1, ack_l, oe_l, we_l, doe_l);
        check_eq("t5_ack_cycles", {16'd0, ack_l}, 32'h0088);
        check_eq("t5_oe_cycles", {16'd0, oe_l}, 32'h0066);

        // Six contended transactions alternate, CPU first after reset
        do_reset(2);
        for (int j = 0; j < 6; j++)
            expect_txn(j[0], 1'b1, init_val(((j % 2) ? 32'h200 : 32'h100) + j / 2));
        cpu_we = 1'b0; cpu_addr = 20'h00100;
        dbg_we = 1'b0; dbg_addr = 20'h00200;
        cpu_req = 1'b1; dbg_req = 1'b1;
        got = 0; cpu_k = 0; dbg_k = 0;
        for (int c = 0; c < 60 && got < 6; c++) begin
            @(negedge Clk);
            if (cpu_ack || dbg_ack) begin
                got++;
                ack_port = dbg_ack;
                @(posedge Clk); #1;
                if (got == 6) begin
                    cpu_req = 1'b0; dbg_req = 1'b0;
                end else if (ack_port) begin
                    dbg_k++; dbg_addr = 20'h00200 + 20'(dbg_k);
                end else begin
                    cpu_k++; cpu_addr = 20'h00100 + 20'(cpu_k);
                end
            end
        end
        check_eq("t3_ack_count", got, 32'd6);
        cpu_req = 1'b0; dbg_req = 1'b0;
        repeat (2) begin @(posedge Clk); #1; end

        // Reset during the second ACCESS cycle of a write aborts it
        expect_txn(1'b0, 1'b0, 16'h0);
        drive(1'b0, 1'b1, 20'h00030, 16'h5555);
        @(negedge Clk);
        @(posedge Clk); #1;
        @(negedge Clk);
        check_eq("t4_we_c1", {31'd0, Mem_WE}, 32'd0);
        @(posedge Clk); #1;
        Reset = 1'b1;
        @(negedge Clk);
        check_eq("t4_we_c2", {31'd0, Mem_WE}, 32'd0);
        check_eq("t4_doe_c2", {31'd0, Data_oe}, 32'd1);
        @(posedge Clk); #1;
        Reset = 1'b0;
        @(negedge Clk);
        check_eq("t4_we_abort", {31'd0, Mem_WE}, 32'd1);
        check_eq("t4_ce_abort", {31'd0, Mem_CE}, 32'd1);
        check_eq("t4_doe_abort", {31'd0, Data_oe}, 32'd0);
        check_eq("t4_no_ack", {30'd0, cpu_ack, dbg_ack}, 32'd0);
        check_eq("t4_state", {30'd0, dut.state}, {30'd0, IDLE});
        ack_cyc = -1;
        for (int k = 4; k < 12; k++) begin
            @(posedge Clk); #1;
            if (ack_cyc >= 0 && k == ack_cyc + 1) cpu_req = 1'b0;
            @(negedge Clk);
            if (cpu_ack && ack_cyc < 0) ack_cyc = k;
        end
        check_eq("t4_regrant_ack", ack_cyc, 32'd6);
        @(posedge Clk); #1;
        cpu_req = 1'b0;
        expect_txn(1'b0, 1'b1, 16'h5555);
        run_single(1'b0, 1'b0, 20'h00030, 16'h0, 0, ack_l, oe_l, we_l, doe_l);
        check_eq("t4_rb_ack", {16'd0, ack_l}, 32'h0008);

        repeat (3) @(posedge Clk);
        check_eq("sb_drain", sb.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
